// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised sequence detector.
package seq_det_pkg;

    // Configuration loaded by reset: the classic 4-bit "0101" overlapping detector.
    localparam logic [7:0] DEF_PATTERN = 8'b0000_0101;
    localparam int         DEF_LEN     = 4;
    localparam bit         DEF_OVERLAP = 1'b1;

    // Lengths beyond the physical history depth are treated as the full depth.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned n_max);
        return (len > n_max) ? n_max : len;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr has priority over inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat
);

    logic [W-1:0] count_q;

    // Count register: synchronous reset, clear, or saturating increment.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
        if (reset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && !sat) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;
    assign sat   = &count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Run-time configurable serial pattern detector with a saturating match counter.
// Detector state is carried by the fill counter: 0 = empty, below eff_len = filling,
// at/above eff_len = armed; y marks the cycle after a matching bit.
module seq_detector_param
    import seq_det_pkg::clamp_len;
#(
    parameter int               N_MAX       = 8,
    parameter int               LEN_W       = $clog2(N_MAX + 1),
    parameter int               CNT_W       = 8,
    parameter logic [N_MAX-1:0] DEF_PATTERN = N_MAX'(seq_det_pkg::DEF_PATTERN),
    parameter int               DEF_LEN     = seq_det_pkg::DEF_LEN,
    parameter bit               DEF_OVERLAP = seq_det_pkg::DEF_OVERLAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             valid,
    input  logic             load,
    input  logic [N_MAX-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    output logic             y,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    logic [N_MAX-1:0] pat_q,  pat_d;
    logic [LEN_W-1:0] len_q,  len_d;
    logic             ovl_q,  ovl_d;
    logic [N_MAX-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             y_q,    y_d;

    logic [LEN_W-1:0] eff_len;
    logic [N_MAX-1:0] mask;
    logic [N_MAX-1:0] hist_shift;
    logic [LEN_W-1:0] fill_inc;
    logic             accept;
    logic             match;
    logic             cnt_inc;
    logic             cnt_clr;

    // Effective length and the compare mask covering its low eff_len bits.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        mask    = '0;
        eff_len = LEN_W'(clamp_len(32'(len_q), N_MAX));
        for (int i = 0; i < N_MAX; i++) begin
            mask[i] = (i < int'(eff_len));
        end
    end

    assign accept     = valid && !load;
    assign hist_shift = {hist_q[N_MAX-2:0], x};
    assign fill_inc   = (fill_q == LEN_W'(N_MAX)) ? fill_q : fill_q + LEN_W'(1);
    assign match      = accept && (eff_len != '0) && (fill_inc >= eff_len)
                        && ((hist_shift & mask) == (pat_q & mask));

    // Next-state: load flushes and reconfigures, an accepted bit shifts and may match.
    always_comb begin
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        y_d     = 1'b0;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        if (load) begin
            pat_d   = cfg_pattern;
            len_d   = cfg_len;
            ovl_d   = cfg_overlap;
            hist_d  = '0;
            fill_d  = '0;
            cnt_clr = 1'b1;
        end else if (valid) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            if (match) begin
                y_d     = 1'b1;
                cnt_inc = 1'b1;
                // Non-overlapping mode demands a full set of fresh bits for the next hit.
                if (!ovl_q) begin
                    fill_d = '0;
                end
            end
        end
    end

    // State register; reset restores the default configuration and empties the detector.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q  <= DEF_PATTERN;
            len_q  <= LEN_W'(DEF_LEN);
            ovl_q  <= DEF_OVERLAP;
            hist_q <= '0;
            fill_q <= '0;
            y_q    <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            y_q    <= y_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (cnt_inc),
        .clr  (cnt_clr),
        .count(match_count),
        .sat  (count_sat)
    );

    assign y = y_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param; a second instance with a 2-bit counter covers saturation.
module tb_seq_detector_param;

    localparam int N_MAX = 8;
    localparam int LEN_W = $clog2(N_MAX + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             x = 1'b0;
    logic             valid = 1'b0;
    logic             load = 1'b0;
    logic [N_MAX-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_overlap = 1'b0;

    logic             y,  y2;
    logic [7:0]       match_count;
    logic [1:0]       match_count2;
    logic             count_sat, count_sat2;

    int n_assert = 0;
    int n_fail   = 0;

    seq_detector_param #(.N_MAX(N_MAX), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .valid      (valid),
        .load       (load),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .y          (y),
        .match_count(match_count),
        .count_sat  (count_sat)
    );

    seq_detector_param #(.N_MAX(N_MAX), .CNT_W(2)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .valid      (valid),
        .load       (load),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .y          (y2),
        .match_count(match_count2),
        .count_sat  (count_sat2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one bit for one edge, then sample 1ns after the edge.
    task automatic step(input logic xb, input logic vb);
        x     = xb;
        valid = vb;
        load  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Load a configuration; the bit offered alongside must be discarded.
    task automatic do_load(input logic [N_MAX-1:0] p, input logic [LEN_W-1:0] l, input logic o);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        load        = 1'b1;
        valid       = 1'b1;
        x           = 1'b1;
        @(posedge clk);
        #1;
        load  = 1'b0;
        valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid = 1'b0;
        load  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] bits;
        logic [7:0] exp_y;
        logic [1:0] exp_c2 [5];
        logic       exp_s2 [5];

        // Reset defaults.
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_y", 32'(y), 32'd0);
        check("reset_count", 32'(match_count), 32'd0);
        check("reset_sat", 32'(count_sat), 32'd0);

        // Default pattern 0101, overlap: hits after bits 4, 6, 8.
        bits  = 8'b0101_0101;
        exp_y = 8'b0001_0101;
        for (int i = 7; i >= 0; i--) begin
            step(bits[i], 1'b1);
            check($sformatf("ovl_y_bit%0d", 8 - i), 32'(y), 32'(exp_y[i]));
        end
        check("ovl_count", 32'(match_count), 32'd3);

        // Non-overlapping 0101: hits after bits 4 and 8 only.
        do_load(8'b0000_0101, 4'd4, 1'b0);
        check("load_clears_count", 32'(match_count), 32'd0);
        check("load_y", 32'(y), 32'd0);
        exp_y = 8'b0001_0001;
        for (int i = 7; i >= 0; i--) begin
            step(bits[i], 1'b1);
            check($sformatf("novl_y_bit%0d", 8 - i), 32'(y), 32'(exp_y[i]));
        end
        check("novl_count", 32'(match_count), 32'd2);

        // Pattern 110 with a valid=0 gap: hits after accepted bits 3 and 6.
        do_load(8'b0000_0110, 4'd3, 1'b1);
        step(1'b1, 1'b1); check("gap_y_a1", 32'(y), 32'd0);
        step(1'b1, 1'b1); check("gap_y_a2", 32'(y), 32'd0);
        step(1'b0, 1'b0); check("gap_y_g1", 32'(y), 32'd0);
        step(1'b1, 1'b0); check("gap_y_g2", 32'(y), 32'd0);
        step(1'b0, 1'b0); check("gap_y_g3", 32'(y), 32'd0);
        check("gap_count_hold", 32'(match_count), 32'd0);
        step(1'b0, 1'b1); check("gap_y_a3", 32'(y), 32'd1);
        step(1'b1, 1'b1); check("gap_y_a4", 32'(y), 32'd0);
        step(1'b1, 1'b1); check("gap_y_a5", 32'(y), 32'd0);
        step(1'b0, 1'b1); check("gap_y_a6", 32'(y), 32'd1);
        step(1'b0, 1'b0); check("gap_y_idle", 32'(y), 32'd0);
        check("gap_count", 32'(match_count), 32'd2);

        // Length 0 disables matching even though zeros keep arriving.
        do_load(8'b0000_0000, 4'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1);
            check($sformatf("len0_y_%0d", i), 32'(y), 32'd0);
        end
        check("len0_count", 32'(match_count), 32'd0);

        // Length 9 clamps to 8: only the eighth bit of 10110010 completes a match.
        do_load(8'b1011_0010, 4'd9, 1'b1);
        bits  = 8'b1011_0010;
        exp_y = 8'b0000_0001;
        for (int i = 7; i >= 0; i--) begin
            step(bits[i], 1'b1);
            check($sformatf("len9_y_bit%0d", 8 - i), 32'(y), 32'(exp_y[i]));
        end
        check("len9_count", 32'(match_count), 32'd1);

        // Pattern 1, length 1: continuous y, 2-bit counter saturates at 3.
        do_load(8'b0000_0001, 4'd1, 1'b1);
        exp_c2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        exp_s2 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1);
            check($sformatf("sat_y_%0d", i), 32'(y2), 32'd1);
            check($sformatf("sat_count_%0d", i), 32'(match_count2), 32'(exp_c2[i]));
            check($sformatf("sat_flag_%0d", i), 32'(count_sat2), 32'(exp_s2[i]));
        end
        check("wide_count", 32'(match_count), 32'd5);
        step(1'b1, 1'b0);
        check("sat_y_idle", 32'(y2), 32'd0);
        check("sat_count_hold", 32'(match_count2), 32'd3);

        // Reset mid-pattern: partial 010 is discarded, defaults return.
        do_load(8'b0000_0101, 4'd4, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        do_reset();
        check("rst_mid_y", 32'(y), 32'd0);
        check("rst_mid_count", 32'(match_count), 32'd0);
        check("rst_mid_sat2", 32'(count_sat2), 32'd0);
        bits  = 8'b0001_0101;
        exp_y = 8'b0000_0001;
        for (int i = 4; i >= 0; i--) begin
            step(bits[i], 1'b1);
            check($sformatf("rst_y_bit%0d", 5 - i), 32'(y), 32'(exp_y[i]));
        end
        check("rst_count", 32'(match_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
